// File: rtl/hbridge_coil_pkg.sv
// Shared types for the behavioural H-bridge / coil model.
// Provides the bridge state enum and the gate decoder used by every channel.
package hbridge_coil_pkg;

  typedef enum logic [2:0] {
    DRIVE_POS,
    DRIVE_NEG,
    SLOW_DECAY,
    FAST_DECAY,
    SHOOT_THROUGH
  } bridge_state_t;

  // Priority decode of the four gates; invert swaps the two drive directions.
  function automatic bridge_state_t decode_bridge(
    input logic high_1,
    input logic low_1,
    input logic high_2,
    input logic low_2,
    input logic invert
  );
    bridge_state_t st;
    if ((high_1 && low_1) || (high_2 && low_2)) st = SHOOT_THROUGH;
    else if (high_1 && low_2)                   st = invert ? DRIVE_NEG : DRIVE_POS;
    else if (high_2 && low_1)                   st = invert ? DRIVE_POS : DRIVE_NEG;
    else if ((low_1 && low_2) || (high_1 && high_2)) st = SLOW_DECAY;
    else                                        st = FAST_DECAY;
    return st;
  endfunction

endpackage

// File: rtl/hbridge_coil_array_if.sv
// Bundle of per-channel bridge signals between the stepper driver and the coil model.
// master: drives gates, invert, PWM reference and fault clears; reads coil state.
// slave : the coil model side.
interface hbridge_coil_array_if #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned CURRENT_W = 13,
  parameter int unsigned DUTY_W    = 12
);
  logic [CHANNELS-1:0]           low_1;
  logic [CHANNELS-1:0]           high_1;
  logic [CHANNELS-1:0]           low_2;
  logic [CHANNELS-1:0]           high_2;
  logic [CHANNELS-1:0]           polarity_invert;
  logic [CHANNELS-1:0]           analog_out;
  logic [CHANNELS-1:0]           fault_clear;
  logic [CHANNELS-1:0]           analog_cmp;
  logic [CHANNELS-1:0]           fault;
  logic [CHANNELS*CURRENT_W-1:0] current;
  logic [CHANNELS*DUTY_W-1:0]    target;

  modport master (
    output low_1, high_1, low_2, high_2, polarity_invert, analog_out, fault_clear,
    input  analog_cmp, fault, current, target
  );

  modport slave (
    input  low_1, high_1, low_2, high_2, polarity_invert, analog_out, fault_clear,
    output analog_cmp, fault, current, target
  );
endinterface

// File: rtl/hbridge_coil_channel.sv
// One coil: gate decode, saturating current integrator, PWM duty measurement,
// sticky shoot-through flag and delayed current-vs-reference comparator.
// Ports: clk, reset (sync, active-high), wrap (window counter all-ones strobe),
//        gate inputs, polarity_invert, analog_out, fault_clear ->
//        current (signed), target, fault, analog_cmp.
module hbridge_coil_channel
  import hbridge_coil_pkg::*;
#(
  parameter int unsigned CURRENT_W = 13,
  parameter int unsigned DUTY_W    = 12,
  parameter int unsigned RISE_STEP = 4,
  parameter int unsigned SLOW_STEP = 1,
  parameter int unsigned FAST_STEP = 8,
  parameter int unsigned CMP_DELAY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wrap,
  input  logic                        low_1,
  input  logic                        high_1,
  input  logic                        low_2,
  input  logic                        high_2,
  input  logic                        polarity_invert,
  input  logic                        analog_out,
  input  logic                        fault_clear,
  output logic signed [CURRENT_W-1:0] current,
  output logic [DUTY_W-1:0]           target,
  output logic                        fault,
  output logic                        analog_cmp
);

  localparam int          MAX_I  = (1 << DUTY_W) - 1;
  localparam int          RISE_I = int'(RISE_STEP);
  localparam int          SLOW_I = int'(SLOW_STEP);
  localparam int          FAST_I = int'(FAST_STEP);
  localparam int unsigned CNT_W  = DUTY_W + 1;

  bridge_state_t               state_c;
  logic signed [CURRENT_W-1:0] current_next_c;
  logic [DUTY_W-1:0]           mag_c;
  logic                        cmp_raw_c;
  logic [CNT_W-1:0]            duty_cnt_q;
  logic [CMP_DELAY-1:0]        cmp_pipe_q;
  int                          cur_i;
  int                          step_i;
  int                          next_i;

  // Bridge decode, next current and raw comparator.
  always_comb begin
    state_c        = decode_bridge(high_1, low_1, high_2, low_2, polarity_invert);
    cur_i          = int'(current);
    step_i         = (state_c == SLOW_DECAY) ? SLOW_I : FAST_I;
    next_i         = cur_i;
    unique case (state_c)
      DRIVE_POS: next_i = (cur_i + RISE_I > MAX_I) ? MAX_I : cur_i + RISE_I;
      DRIVE_NEG: next_i = (cur_i - RISE_I < -MAX_I) ? -MAX_I : cur_i - RISE_I;
      SLOW_DECAY, FAST_DECAY: begin
        // Decay shrinks magnitude toward zero and never crosses it.
        if (cur_i > step_i)       next_i = cur_i - step_i;
        else if (cur_i < -step_i) next_i = cur_i + step_i;
        else                      next_i = 0;
      end
      default:   next_i = cur_i;
    endcase
    current_next_c = CURRENT_W'(next_i);
    // |current| never exceeds MAX, so it fits DUTY_W bits.
    mag_c          = DUTY_W'((cur_i < 0) ? -cur_i : cur_i);
    cmp_raw_c      = (mag_c >= target);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      current    <= '0;
      target     <= '0;
      fault      <= 1'b0;
      duty_cnt_q <= '0;
      cmp_pipe_q <= '1;
    end else begin
      current <= current_next_c;
      // A new shoot-through wins over a clear in the same cycle.
      if (state_c == SHOOT_THROUGH) fault <= 1'b1;
      else if (fault_clear)         fault <= 1'b0;
      // The wrap-cycle sample belongs to the next window.
      if (wrap) begin
        target     <= (duty_cnt_q > CNT_W'(MAX_I)) ? DUTY_W'(MAX_I) : duty_cnt_q[DUTY_W-1:0];
        duty_cnt_q <= CNT_W'(analog_out);
      end else begin
        duty_cnt_q <= duty_cnt_q + CNT_W'(analog_out);
      end
      // Shift toward the MSB; truncation also covers a single-stage pipe.
      cmp_pipe_q <= CMP_DELAY'({cmp_pipe_q, cmp_raw_c});
    end
  end

  assign analog_cmp = cmp_pipe_q[CMP_DELAY-1];

endmodule

// File: rtl/hbridge_coil_array.sv
// N-channel behavioural H-bridge / coil model for closed-loop stepper simulation.
// Ports: clk, reset (sync, active-high), bus (slave side of hbridge_coil_array_if).
// Holds the shared PWM window counter and packs per-channel results onto flat buses.
module hbridge_coil_array
  import hbridge_coil_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned CURRENT_W = 13,
  parameter int unsigned DUTY_W    = 12,
  parameter int unsigned RISE_STEP = 4,
  parameter int unsigned SLOW_STEP = 1,
  parameter int unsigned FAST_STEP = 8,
  parameter int unsigned CMP_DELAY = 2
) (
  input logic                 clk,
  input logic                 reset,
  hbridge_coil_array_if.slave bus
);

  logic [DUTY_W-1:0]             win_q;
  logic                          wrap_c;
  logic [CHANNELS-1:0]           cmp_v;
  logic [CHANNELS-1:0]           fault_v;
  logic [CHANNELS*CURRENT_W-1:0] current_v;
  logic [CHANNELS*DUTY_W-1:0]    target_v;

  // Free-running measurement window shared by all channels.
  always_ff @(posedge clk) begin
    if (reset) win_q <= '0;
    else       win_q <= win_q + DUTY_W'(1);
  end

  assign wrap_c = &win_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    hbridge_coil_channel #(
      .CURRENT_W (CURRENT_W),
      .DUTY_W    (DUTY_W),
      .RISE_STEP (RISE_STEP),
      .SLOW_STEP (SLOW_STEP),
      .FAST_STEP (FAST_STEP),
      .CMP_DELAY (CMP_DELAY)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .wrap            (wrap_c),
      .low_1           (bus.low_1[i]),
      .high_1          (bus.high_1[i]),
      .low_2           (bus.low_2[i]),
      .high_2          (bus.high_2[i]),
      .polarity_invert (bus.polarity_invert[i]),
      .analog_out      (bus.analog_out[i]),
      .fault_clear     (bus.fault_clear[i]),
      .current         (current_v[i*CURRENT_W +: CURRENT_W]),
      .target          (target_v[i*DUTY_W +: DUTY_W]),
      .fault           (fault_v[i]),
      .analog_cmp      (cmp_v[i])
    );
  end

  assign bus.analog_cmp = cmp_v;
  assign bus.fault      = fault_v;
  assign bus.current    = current_v;
  assign bus.target     = target_v;

endmodule

// File: doc/hbridge_coil_array.md
# hbridge_coil_array

Parametrised N-channel behavioural H-bridge/coil model for closed-loop simulation of the microstepper. Decodes each channel's four gate signals into a drive/decay state and integrates a signed coil current. Recovers the PWM-DAC reference from each `analog_out` line and drives a delayed `analog_cmp` back into the DUT. Adds three things the single-coil model lacks: channel-count generality, shoot-through fault detection, and a configurable comparator latency.

## Interface
Parameters:
- `CHANNELS`, 2: number of coils.
- `CURRENT_W`, 13: signed current width.
- `DUTY_W`, 12: PWM measurement width; window is 2^DUTY_W cycles.
- `RISE_STEP`, 4: magnitude change per cycle while driving.
- `SLOW_STEP`, 1: decay per cycle in slow decay.
- `FAST_STEP`, 8: decay per cycle in fast decay.
- `CMP_DELAY`, 2: comparator pipeline depth, ≥1.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `low_1`, `high_1`, `low_2`, `high_2` in CHANNELS: gate drives, bit i = channel i.
- `polarity_invert` in CHANNELS: negate drive direction per channel.
- `analog_out` in CHANNELS: PWM reference from DUT.
- `analog_cmp` out CHANNELS: current ≥ reference, delayed.
- `current` out CHANNELS*CURRENT_W: signed coil currents; channel i at `[i*CURRENT_W +: CURRENT_W]`.
- `target` out CHANNELS*DUTY_W: measured reference per channel.
- `fault` out CHANNELS: sticky shoot-through flag.
- `fault_clear` in CHANNELS: clears the matching fault bit.

## Operation
Per-channel bridge state is decoded combinationally. Rules are checked in priority order:
- SHOOT_THROUGH: `high_1&low_1` or `high_2&low_2`.
- DRIVE_POS: `high_1&low_2`.
- DRIVE_NEG: `high_2&low_1`.
- SLOW_DECAY: `low_1&low_2` or `high_1&high_2`.
- FAST_DECAY: any other pattern, including all-off.

`polarity_invert` swaps DRIVE_POS and DRIVE_NEG.

Current update rules:
- DRIVE: current ± RISE_STEP, saturating at ±MAX.
- MAX = 2^DUTY_W−1, which is required < 2^(CURRENT_W−1).
- Decay: magnitude reduced by SLOW_STEP or FAST_STEP, clamped at 0. Decay never crosses zero.
- SHOOT_THROUGH: current held.

Fault: set to 1 on any SHOOT_THROUGH cycle. Cleared only by `fault_clear` in a cycle with no new shoot-through; set wins over clear.

PWM measurement:
- One shared window counter, DUTY_W bits, free-running.
- Each channel counts `analog_out` high cycles, DUTY_W+1 bits.
- On counter wrap (all-ones cycle), `target` ← min(count, MAX). The high-cycle counter restarts at 0, plus the current sample.

Comparator:
- `cmp_raw` = |current| ≥ `target`, unsigned DUTY_W compare.
- `cmp_raw` passes through CMP_DELAY registers before reaching `analog_cmp`.

## Timing
- Reset values: `current`=0, `target`=0, `fault`=0, `analog_cmp`=all 1 (including every pipeline stage), window counter=0, duty counters=0.
- `current` reflects the gate state sampled at edge n, visible after edge n.
- `analog_cmp` reflects `current`/`target` from CMP_DELAY cycles earlier.
- `target` updates after the edge where the window counter goes 2^DUTY_W−1 → 0. First valid value appears at cycle 2^DUTY_W after reset release.
- Reset mid-window discards the partial count. Reset mid-fault clears `fault`.
- Channels are fully independent except for the shared window counter.

## Structure
- Package `hbridge_coil_pkg`: bridge state enum (DRIVE_POS, DRIVE_NEG, SLOW_DECAY, FAST_DECAY, SHOOT_THROUGH) and a decode function taking gates and invert.
- Sub-module `hbridge_coil_channel`: decode, current integrator, duty counter, fault, comparator pipeline.
  - Generated CHANNELS times.
  - Takes a window-wrap strobe input.
- Top level holds the window counter and the flat port packing.

## Test plan
Defaults are used except where noted.
1. Reset, then idle inputs → `current`=0, `target`=0, `fault`=0, `analog_cmp`=2'b11 held through reset.
2. Channel 0 DRIVE_POS for 100 cycles → `current[0]`=400. Then all-off for 10 cycles → 320. Then all-off for 100 more cycles → 0, with no negative overshoot. Channel 1 stays 0 throughout.
3. DRIVE_NEG for 2000 cycles → `current` saturates at −4095. With `polarity_invert`=1, the same gates give +4095.
4. `analog_out[0]` high for 1024 of each 4096 cycles → `target[0]`=1024 after the first wrap. Constant 1 → 4095. Constant 0 → 0.
5. `target[0]`=400, then DRIVE_POS from 0 → `analog_cmp[0]` rises exactly 2 cycles after `current[0]` reaches 400.
6. Channel 1 with `high_1`=`low_1`=1 for 1 cycle → `fault[1]`=1 next cycle, `current[1]` held, fault persists. `fault_clear[1]` → 0, unless shoot-through recurs in the same cycle.
